memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 32 +++
 rtl/memory_arbiter.sv | 99 +++++++++
 tb/tb_memory_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bundle of the instruction port, data port and shared RAM port around memory_arbiter.
// slave is the arbiter's view; master is the surrounding requesters and RAM.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        ram_ready;
    logic [31:0] ram_load;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
        output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
        input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM between an instruction fetch port and a data port.
// Data normally wins; an instruction left waiting through STARVE_MAX data grants goes next.
module memory_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic             CLK,
    input logic             RST,
    memory_arbiter_if.slave bus
);
    localparam int unsigned   CW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          ren_q;
    logic          wen_q;
    logic [31:0]   addr_q;
    logic [31:0]   store_q;

    logic          data_req;
    logic          starved;
    logic          i_done;
    logic          d_done;

    always_comb begin
        data_req = bus.dREN | bus.dWEN;
        starved  = (starve_cnt == STARVE_LIM) & bus.iREN;
        i_done   = (state == IGNT) & bus.ram_ready;
        d_done   = (state == DGNT) & bus.ram_ready;
    end

    // The RAM-facing registers double as the latched winner fields: loaded on the
    // IDLE->grant edge, held for the whole access, and zeroed on the way back to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req && !starved) begin
                        state   <= DGNT;
                        ren_q   <= ~bus.dWEN;
                        wen_q   <= bus.dWEN;
                        addr_q  <= bus.daddr;
                        store_q <= bus.dstore;
                        if (bus.iREN && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (bus.iREN) begin
                        state      <= IGNT;
                        ren_q      <= 1'b1;
                        wen_q      <= 1'b0;
                        addr_q     <= bus.iaddr;
                        store_q    <= '0;
                        starve_cnt <= '0;
                    end
                end
                IGNT, DGNT: begin
                    if (bus.ram_ready) begin
                        state   <= IDLE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        addr_q  <= '0;
                        store_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    addr_q  <= '0;
                    store_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.ram_ren   = ren_q;
        bus.ram_wen   = wen_q;
        bus.ram_addr  = addr_q;
        bus.ram_store = store_q;
        bus.iwait     = bus.iREN & ~i_done;
        bus.dwait     = data_req & ~d_done;
        bus.iload     = i_done ? bus.ram_load : '0;
        bus.dload     = d_done ? bus.ram_load : '0;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: random requesters and RAM, with a grant-level
// reference model in the monitor and expected read data queued at request issue.
module tb_memory_arbiter;
    localparam int unsigned SMAX = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    memory_arbiter_if bus();

    memory_arbiter #(.STARVE_MAX(SMAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] iq[$];
    exp_t        dq[$];
    bit          glog[$];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int unsigned ready_pct = 0;
    bit          i_out = 0, d_out = 0, i_fin = 0, d_fin = 0, d_wr = 0;
    logic [31:0] d_a = '0, d_s = '0;

    // monitor model state
    bit          m_busy = 0, m_kd = 0, m_rst_prev = 1;
    bit          m_p_i = 0, m_p_d = 0, m_p_w = 0, m_p_rdy = 0;
    logic [31:0] m_p_ia = '0, m_p_da = '0, m_p_ds = '0;
    bit          m_ren = 0, m_wen = 0;
    logic [31:0] m_addr = '0, m_store = '0;
    int unsigned m_cnt = 0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return mem_init(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic at_pos();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    task automatic issue_i(input logic [31:0] a, input logic [31:0] exp);
        bus.iaddr = a;
        bus.iREN  = 1'b1;
        i_out     = 1'b1;
        iq.push_back(exp);
    endtask

    task automatic issue_d(input logic [31:0] a, input logic [31:0] s, input bit wr, input bit both);
        exp_t e;
        bus.daddr  = a;
        bus.dstore = s;
        bus.dWEN   = wr;
        bus.dREN   = !wr || both;
        d_out = 1'b1;
        d_wr  = wr;
        d_a   = a;
        d_s   = s;
        e.wr   = wr;
        e.data = wr ? '0 : ref_rd(a);
        dq.push_back(e);
    endtask

    task automatic step(input int unsigned ip, input int unsigned dp, input bit allow_new);
        logic [31:0] a;
        bit          wr;
        if (i_fin) begin
            i_fin = 0;
            i_out = 0;
            bus.iREN = 1'b0;
        end
        if (d_fin) begin
            d_fin = 0;
            d_out = 0;
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
            if (d_wr) ref_mem[d_a] = d_s;
        end
        if (allow_new && !i_out && $urandom_range(99) < ip) begin
            a = 32'h1000_0000 | (32'($urandom_range(1023)) << 2);
            issue_i(a, mem_init(a));
        end
        if (allow_new && !d_out && $urandom_range(99) < dp) begin
            a  = 32'h8000_0000 | (32'($urandom_range(15)) << 2);
            wr = ($urandom_range(1) == 1);
            issue_d(a, $urandom, wr, $urandom_range(2) == 0);
        end
    endtask

    task automatic run_traffic(input int n, input int unsigned ip, input int unsigned dp);
        for (int c = 0; c < n; c++) begin
            at_pos();
            step(ip, dp, 1'b1);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((i_out || d_out) && n < 500) begin
            at_pos();
            step(0, 0, 1'b0);
            n++;
        end
        check({tag, "_drain_pending"}, 32'(i_out || d_out), 32'd0);
    endtask

    // RAM model: commits writes on completion, randomises ready (also while idle)
    initial begin
        bus.ram_ready = 1'b0;
        bus.ram_load  = '0;
        forever begin
            @(negedge CLK);
            if (bus.ram_wen && bus.ram_ready) ram_mem[bus.ram_addr] = bus.ram_store;
            @(posedge CLK);
            #1;
            bus.ram_ready = ($urandom_range(99) < ready_pct);
            bus.ram_load  = bus.ram_ren ? ram_rd(bus.ram_addr) : $urandom;
        end
    end

    // Monitor: grant-level reference model plus scoreboard pops on completion
    initial begin
        bit   ic, dc;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (m_rst_prev) begin
                m_busy = 0;
                m_cnt  = 0;
                iq.delete();
                dq.delete();
            end else if (m_busy && m_p_rdy) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (m_p_d && !(m_cnt == SMAX && m_p_i)) begin
                    m_busy = 1; m_kd = 1;
                    m_ren = !m_p_w; m_wen = m_p_w;
                    m_addr = m_p_da; m_store = m_p_ds;
                    if (m_p_i && m_cnt < SMAX) m_cnt++;
                    glog.push_back(1'b1);
                end else if (m_p_i) begin
                    m_busy = 1; m_kd = 0;
                    m_ren = 1; m_wen = 0;
                    m_addr = m_p_ia; m_store = '0;
                    m_cnt = 0;
                    glog.push_back(1'b0);
                end
            end

            check("ram_ren", 32'(bus.ram_ren), 32'(m_busy && m_ren));
            check("ram_wen", 32'(bus.ram_wen), 32'(m_busy && m_wen));
            check("ram_addr", bus.ram_addr, m_busy ? m_addr : '0);
            check("ram_store", bus.ram_store, m_busy ? m_store : '0);

            ic = m_busy && !m_kd && bus.ram_ready;
            dc = m_busy && m_kd && bus.ram_ready;
            check("iwait", 32'(bus.iwait), 32'(bus.iREN && !ic));
            check("dwait", 32'(bus.dwait), 32'((bus.dREN || bus.dWEN) && !dc));

            if (ic && bus.iREN) begin
                check("iq_nonempty", 32'(iq.size() > 0), 32'd1);
                if (iq.size() > 0) check("iload", bus.iload, iq.pop_front());
                i_fin = 1;
            end else if (!ic) begin
                check("iload_zero", bus.iload, '0);
            end

            if (dc && (bus.dREN || bus.dWEN)) begin
                check("dq_nonempty", 32'(dq.size() > 0), 32'd1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    if (!e.wr) check("dload", bus.dload, e.data);
                end
                d_fin = 1;
            end else if (!dc) begin
                check("dload_zero", bus.dload, '0);
            end

            m_p_i      = bus.iREN;
            m_p_d      = bus.dREN || bus.dWEN;
            m_p_w      = bus.dWEN;
            m_p_ia     = bus.iaddr;
            m_p_da     = bus.daddr;
            m_p_ds     = bus.dstore;
            m_p_rdy    = bus.ram_ready;
            m_rst_prev = RST;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rp[3];
        rp = '{60, 25, 100};

        // Reset held two edges with an instruction request pending
        RST = 1'b1;
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0;  bus.dstore = '0;
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        i_out = 1'b1;
        ram_mem[32'h40] = 32'hDEAD_BEEF;
        at_neg();
        check("rst_ram_ren_a", 32'(bus.ram_ren), 32'd0);
        check("rst_iwait_a", 32'(bus.iwait), 32'd1);
        at_pos();
        RST = 1'b0;
        at_neg();
        check("rst_ram_ren_b", 32'(bus.ram_ren), 32'd0);
        check("rst_iwait_b", 32'(bus.iwait), 32'd1);
        at_pos();
        iq.push_back(32'hDEAD_BEEF);
        at_neg();
        check("post_rst_ram_ren", 32'(bus.ram_ren), 32'd1);
        check("ifetch_addr", bus.ram_addr, 32'h40);
        ready_pct = 100;
        at_neg();
        check("ifetch_iwait", 32'(bus.iwait), 32'd0);
        check("ifetch_iload", bus.iload, 32'hDEAD_BEEF);
        check("ifetch_addr_done", bus.ram_addr, 32'h40);
        drain("ifetch");
        at_neg();
        check("ifetch_back_idle", 32'(bus.ram_ren), 32'd0);

        // Simultaneous requests: data first, then instruction
        at_pos();
        glog.delete();
        issue_i(32'h44, mem_init(32'h44));
        issue_d(32'h8000_0010, 32'h0, 1'b0, 1'b0);
        drain("contend");
        check("contend_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("contend_first", 32'(glog[0]), 32'd1);
            check("contend_second", 32'(glog[1]), 32'd0);
        end

        // Both sides held continuously: four data grants then one instruction grant
        glog.delete();
        run_traffic(44, 100, 100);
        drain("starve");
        for (int n = 0; n < 10; n++) begin
            check($sformatf("starve_seq%0d", n),
                  (n < glog.size()) ? 32'(glog[n]) : 32'd2, 32'((n % 5) != 4));
        end

        // dREN and dWEN together: write wins
        ready_pct = 0;
        issue_d(32'h80, 32'h1234, 1'b1, 1'b1);
        at_neg();
        at_neg();
        check("wprio_wen", 32'(bus.ram_wen), 32'd1);
        check("wprio_ren", 32'(bus.ram_ren), 32'd0);
        check("wprio_store", bus.ram_store, 32'h1234);
        check("wprio_addr", bus.ram_addr, 32'h80);
        ready_pct = 100;
        drain("wprio");
        issue_d(32'h80, 32'h0, 1'b0, 1'b0);
        drain("wprio_rb");

        // Reset during a write before ready: aborted with no completion
        ready_pct = 0;
        issue_d(32'h84, 32'h5555_AAAA, 1'b1, 1'b0);
        at_neg();
        at_neg();
        check("abort_wen_before", 32'(bus.ram_wen), 32'd1);
        at_pos();
        RST = 1'b1;
        at_pos();
        at_neg();
        check("abort_wen_after", 32'(bus.ram_wen), 32'd0);
        check("abort_dwait", 32'(bus.dwait), 32'd1);
        at_pos();
        bus.dWEN = 1'b0; bus.dREN = 1'b0;
        d_out = 1'b0;
        RST = 1'b0;
        ready_pct = 100;
        at_pos();
        issue_d(32'h84, 32'h0, 1'b0, 1'b0);
        drain("abort_rb");

        // Random traffic under several RAM latencies
        for (int s = 0; s < 3; s++) begin
            ready_pct = rp[s];
            run_traffic(1000, 40 + 20 * s, 70 - 10 * s);
            drain($sformatf("rand%0d", s));
        end

        at_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
